// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_pkg
// Description : Shared defaults, broadcast entry type and pointer helper for
//               the common data bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

  localparam int c_default_num_fu     = 4;
  localparam int c_default_data_width = 32;
  localparam int c_default_tag_width  = 7;
  localparam int c_default_src_width  = $clog2(c_default_num_fu);

  // Broadcast entry at the default widths.
  typedef struct packed {
    logic [c_default_data_width-1:0] data;
    logic [c_default_tag_width-1:0]  tag;
    logic [c_default_src_width-1:0]  src;
  } cdb_entry_t;

  function automatic int unsigned cdb_wrap_inc(input int unsigned idx,
                                               input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Functional-unit completion and broadcast bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7
);
  localparam int c_src_w = $clog2(NUM_FU);

  logic [NUM_FU-1:0]            fu_done;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
  logic [NUM_FU-1:0]            fu_queued;
  logic                         cdb_valid;
  logic [DATA_WIDTH-1:0]        cdb_data;
  logic [TAG_WIDTH-1:0]         cdb_tag;
  logic [c_src_w-1:0]           cdb_src;
  logic                         cdb_ready;
  logic                         overflow_err;

  modport master (
    output fu_done, fu_result, fu_tag, cdb_ready,
    input  fu_queued, cdb_valid, cdb_data, cdb_tag, cdb_src, overflow_err
  );

  modport slave (
    input  fu_done, fu_result, fu_tag, cdb_ready,
    output fu_queued, cdb_valid, cdb_data, cdb_tag, cdb_src, overflow_err
  );

endinterface
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_rr_arbiter
// Description : Picks one pending FU. CDB_ROUND_ROBIN_EN selects round-robin
//               from i_ptr; otherwise the lowest pending index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter #(
  parameter int NUM_FU = 4
) (
  input  logic [NUM_FU-1:0]         i_pending,
  input  logic [$clog2(NUM_FU)-1:0] i_ptr,
  output logic [NUM_FU-1:0]         o_grant,
  output logic [$clog2(NUM_FU)-1:0] o_grant_idx,
  output logic                      o_grant_valid
);
  localparam int c_src_w = $clog2(NUM_FU);

  assign o_grant_valid = |i_pending;

`ifdef CDB_ROUND_ROBIN_EN
  logic [c_src_w:0]   w_sum;
  logic [c_src_w-1:0] w_cand;
  logic               w_found;

  // Walk the ring starting at the pointer; the first pending FU wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_sum = {1'b0, i_ptr} + (c_src_w+1)'(k);
      if (w_sum >= (c_src_w+1)'(NUM_FU)) begin
        w_sum = w_sum - (c_src_w+1)'(NUM_FU);
      end
      w_cand = w_sum[c_src_w-1:0];
      if (!w_found && i_pending[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_grant     = '0;
        o_grant[i]  = 1'b1;
        o_grant_idx = c_src_w'(i);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Collects FU completions and broadcasts one per cycle on the
//               common data bus. Macro CDB_ROUND_ROBIN_EN enables round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU     = c_default_num_fu,
  parameter int DATA_WIDTH = c_default_data_width,
  parameter int TAG_WIDTH  = c_default_tag_width
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int c_src_w = $clog2(NUM_FU);

  logic [DATA_WIDTH-1:0] w_slice_data [NUM_FU];
  logic [TAG_WIDTH-1:0]  w_slice_tag  [NUM_FU];

  logic [NUM_FU-1:0]     r_pending;
  logic [DATA_WIDTH-1:0] r_hold_data [NUM_FU];
  logic [TAG_WIDTH-1:0]  r_hold_tag  [NUM_FU];

  logic                  r_cdb_valid;
  logic [DATA_WIDTH-1:0] r_cdb_data;
  logic [TAG_WIDTH-1:0]  r_cdb_tag;
  logic [c_src_w-1:0]    r_cdb_src;
  logic [NUM_FU-1:0]     r_queued;
  logic                  r_overflow;

  logic [c_src_w-1:0]    w_ptr;
  logic [NUM_FU-1:0]     w_grant;
  logic [c_src_w-1:0]    w_grant_idx;
  logic                  w_grant_valid;
  logic                  w_load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_slice
      assign w_slice_data[gi] = bus.fu_result[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_slice_tag[gi]  = bus.fu_tag[gi*TAG_WIDTH +: TAG_WIDTH];
    end
  endgenerate

  cdb_rr_arbiter #(
    .NUM_FU (NUM_FU)
  ) u_arb (
    .i_pending     (r_pending),
    .i_ptr         (w_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Only registered pending bits compete, so a fresh done waits one edge.
  assign w_load = w_grant_valid && (!r_cdb_valid || bus.cdb_ready);

`ifdef CDB_ROUND_ROBIN_EN
  logic [c_src_w-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= c_src_w'(cdb_wrap_inc(32'(w_grant_idx), NUM_FU));
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
      r_cdb_src   <= '0;
      r_queued    <= '0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_hold_data[i] <= '0;
        r_hold_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_done[i]) begin
          // A done on the FU being granted this edge refills the slot cleanly.
          r_pending[i]   <= 1'b1;
          r_hold_data[i] <= w_slice_data[i];
          r_hold_tag[i]  <= w_slice_tag[i];
          if (r_pending[i] && !(w_load && w_grant[i])) begin
            r_overflow <= 1'b1;
          end
        end else if (w_load && w_grant[i]) begin
          r_pending[i] <= 1'b0;
        end
      end

      if (w_load) begin
        r_cdb_valid <= 1'b1;
        r_cdb_data  <= r_hold_data[w_grant_idx];
        r_cdb_tag   <= r_hold_tag[w_grant_idx];
        r_cdb_src   <= w_grant_idx;
        r_queued    <= w_grant;
      end else begin
        r_queued <= '0;
        if (r_cdb_valid && bus.cdb_ready) begin
          r_cdb_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.fu_queued    = r_queued;
  assign bus.cdb_valid    = r_cdb_valid;
  assign bus.cdb_data     = r_cdb_data;
  assign bus.cdb_tag      = r_cdb_tag;
  assign bus.cdb_src      = r_cdb_src;
  assign bus.overflow_err = r_overflow;

endmodule
`default_nettype wire
